// File: rtl/en_data_pkg.sv
// Shared types and default parameters for the enable-qualified data transmitter.
package en_data_pkg;

    // Transmit FSM: wait for data, drive a strobe, or hold off for the idle gap.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_e;

    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 4;
    localparam int GAP_W_DEF = 4;

endpackage

// File: rtl/en_data_fifo.sv
// Small synchronous FIFO: registered pointers and occupancy, head entry read
// combinationally so the transmitter can load it on the same edge it pops.
module en_data_fifo
    import en_data_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DW-1:0]            wr_data,
    input  logic                     pop,
    output logic [DW-1:0]            rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;
    logic [DEPTH-1:0] wr_sel;

    // Guard against overflow/underflow even if a caller misbehaves.
    assign push_ok = push && (count_reg != FULL);
    assign pop_ok  = pop  && (count_reg != '0);

    // One write-select line per entry, decoded from the write pointer.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push_ok && (wr_ptr_reg == AW'(gi));
        end
    endgenerate

    // Storage write; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
                mem[i] <= wr_data;
            end
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/en_data_tx.sv
// Transmit side of the enable-qualified data interface: buffers upstream bytes
// and replays them as single-cycle tx_en strobes separated by a programmable gap.
module en_data_tx
    import en_data_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int GAP_W = GAP_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    input  logic [DW-1:0]            s_data,
    output logic                     s_ready,
    input  logic [GAP_W-1:0]         gap_cfg,
    output logic                     tx_en,
    output logic [DW-1:0]            tx_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    tx_state_e        state_reg;
    logic [GAP_W-1:0] gap_cnt_reg;
    logic             tx_en_reg;
    logic [DW-1:0]    tx_data_reg;

    logic [DW-1:0]    head_data;
    logic [CW-1:0]    fifo_count;
    logic             has_data;
    logic             gap_done;
    logic             push;
    logic             pop;

    // Ready depends on registered occupancy only: a pop on a full FIFO does not
    // open the door in the same cycle.
    assign s_ready  = (fifo_count != FULL);
    assign push     = s_valid && s_ready;
    assign has_data = (fifo_count != '0);
    // A gap counter of 0 cannot arise in GAP, but treat it as expired anyway.
    assign gap_done = (gap_cnt_reg <= GAP_W'(1));

    en_data_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (s_data),
        .pop     (pop),
        .rd_data (head_data),
        .count   (fifo_count)
    );

    // Decide whether the coming edge launches a strobe (and thus pops one entry).
    // GAP pops directly on its last cycle so spacing is exactly gap_cfg idle cycles.
    always_comb begin
        pop = 1'b0;
        case (state_reg)
            IDLE:    pop = has_data;
            SEND:    pop = (gap_cfg == '0) && has_data;
            GAP:     pop = gap_done && has_data;
            default: pop = 1'b0;
        endcase
    end

    // Transmit FSM with gap counter and registered strobe/data outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            gap_cnt_reg <= '0;
            tx_en_reg   <= 1'b0;
            tx_data_reg <= '0;
        end else begin
            tx_en_reg <= pop;
            if (pop) begin
                tx_data_reg <= head_data;
            end
            case (state_reg)
                IDLE: begin
                    if (has_data) begin
                        state_reg <= SEND;
                    end
                end
                SEND: begin
                    // gap_cfg is latched only here, so mid-gap changes wait a strobe.
                    gap_cnt_reg <= gap_cfg;
                    if (gap_cfg != '0) begin
                        state_reg <= GAP;
                    end else if (!has_data) begin
                        state_reg <= IDLE;
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        state_reg <= has_data ? SEND : IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign tx_en   = tx_en_reg;
    assign tx_data = tx_data_reg;
    assign count   = fifo_count;
    assign busy    = has_data || (state_reg != IDLE);

`ifdef FORMAL
    logic [GAP_W:0]   low_run_reg;
    logic [GAP_W-1:0] gap_seen_reg;
    logic             seen_reg;

    // Track idle cycles since the last strobe and the gap it sampled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            low_run_reg  <= '0;
            gap_seen_reg <= '0;
            seen_reg     <= 1'b0;
        end else if (tx_en_reg) begin
            low_run_reg  <= '0;
            gap_seen_reg <= gap_cfg;
            seen_reg     <= 1'b1;
        end else if (low_run_reg != '1) begin
            low_run_reg <= low_run_reg + (GAP_W+1)'(1);
        end
    end

    a_strobe_has_data: assert property (@(posedge clk) disable iff (reset)
        tx_en |-> $past(count) > '0);
    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        count <= FULL);
    a_ready_full: assert property (@(posedge clk) disable iff (reset)
        !s_ready |-> count == FULL);
    a_data_hold: assert property (@(posedge clk) disable iff (reset)
        !tx_en |=> tx_en || $stable(tx_data));
    a_spacing: assert property (@(posedge clk) disable iff (reset)
        (tx_en && seen_reg) |-> low_run_reg >= {1'b0, gap_seen_reg});
`endif

endmodule
